// File: rtl/pending_request_scheduler.sv
// pending_request_scheduler
//   Collects one-cycle request pulses from 8 sources into a pending vector and
//   offers one source at a time to a consumer. It always picks the lowest
//   eligible index, where a source is eligible if it is pending and not masked.
//   Once a grant is offered it is held until accepted. After each accepted grant
//   the scheduler idles for HOLDOFF cycles. A request that arrives for a source
//   that is already pending is a collision, and the number of cycles containing
//   a collision is counted in a saturating counter.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high reset
//   req_in     : [7:0] request pulses, bit i = source i
//   mask       : [7:0] bit i = 1 keeps pending source i from being selected
//   out_ready  : consumer accepts the offered grant
//   out_valid  : a grant is being offered
//   out_pos    : [2:0] granted source index (meaningful while out_valid = 1)
//   pending    : [7:0] registered pending-request vector
//   drop_count : [7:0] saturating collision-cycle counter
module pending_request_scheduler #(
  parameter int HOLDOFF = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req_in,
  input  logic [7:0] mask,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] out_pos,
  output logic [7:0] pending,
  output logic [7:0] drop_count
);

  typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;

  localparam logic [3:0] HOLD_CNT = 4'(HOLDOFF);

  state_t     state_q;
  logic       out_valid_q;
  logic [2:0] out_pos_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] drop_q, drop_d;
  logic [3:0] hold_q;

  logic       hs;
  logic [7:0] clr_vec;
  logic [7:0] coll;
  logic [7:0] eligible;

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Next-state for the pending vector and drop counter. A bit cleared by the
  // handshake and re-requested in the same cycle ends up set again through
  // the OR with req_in, and it is not treated as a collision.
  always_comb begin
    hs        = out_valid_q & out_ready;
    clr_vec   = hs ? (8'd1 << out_pos_q) : 8'd0;
    coll      = req_in & pending_q & ~clr_vec;
    pending_d = (pending_q & ~clr_vec) | req_in;
    drop_d    = (|coll) ? sat_inc(drop_q) : drop_q;
    eligible  = pending_q & ~mask;
  end

  // Selection uses the registered pending vector, so a request needs one cycle
  // to become pending and one more to be offered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_pos_q   <= 3'd0;
      pending_q   <= 8'h00;
      drop_q      <= 8'h00;
      hold_q      <= 4'd0;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            state_q     <= OFFER;
            out_valid_q <= 1'b1;
            out_pos_q   <= lowest_idx(eligible);
          end
        end
        OFFER: begin
          // The grant stays fixed until it is accepted, regardless of
          // new arrivals or changes to the mask.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (HOLD_CNT != 4'd0) begin
              state_q <= HOLD;
              hold_q  <= HOLD_CNT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        HOLD: begin
          hold_q <= hold_q - 4'd1;
          if (hold_q <= 4'd1) state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pos    = out_pos_q;
  assign pending    = pending_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pending_request_scheduler.sv
module tb_pending_request_scheduler;
  localparam int HOLDOFF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req_in = 8'h00;
  logic [7:0] mask = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] out_pos;
  logic [7:0] pending;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pending_request_scheduler #(.HOLDOFF(HOLDOFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_in    (req_in),
    .mask      (mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pos   (out_pos),
    .pending   (pending),
    .drop_count(drop_count)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. A grant is offered whenever nothing is on offer, the
  // current cycle is past the end of the holdoff window, and some pending bit
  // is unmasked.
  bit          m_valid = 1'b0;
  int          m_pos = 0;
  logic [7:0]  m_pend = 8'h00;
  int          m_drop = 0;
  longint      cyc = 0;
  longint      next_eval = 0;
  bit          chk_en = 1'b0;

  function automatic int first_one(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    logic [7:0] clr;
    logic [7:0] elig;
    if (reset) begin
      m_valid   = 1'b0;
      m_pos     = 0;
      m_pend    = 8'h00;
      m_drop    = 0;
      next_eval = cyc + 1;
      chk_en    = 1'b1;
    end else begin
      clr  = (m_valid && out_ready) ? 8'(1 << m_pos) : 8'h00;
      if ((req_in & m_pend & ~clr) != 8'h00 && m_drop < 255) m_drop++;
      elig   = m_pend & ~mask;
      m_pend = (m_pend & ~clr) | req_in;
      if (m_valid) begin
        if (out_ready) begin
          m_valid   = 1'b0;
          next_eval = cyc + HOLDOFF + 1;
        end
      end else if (cyc >= next_eval && elig != 8'h00) begin
        m_valid = 1'b1;
        m_pos   = first_one(elig);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) chk("out_pos", int'(out_pos), m_pos);
      chk("pending", int'(pending), int'(m_pend));
      chk("drop_count", int'(drop_count), m_drop);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req_in = 8'h00;
    tick();
    reset  = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    for (int i = 0; i < maxc && !out_valid; i++) tick();
    ok = out_valid;
  endtask

  initial begin
    bit ok;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_drop", int'(drop_count), 0);

    // Two requests, served lowest-first with the holdoff gap between grants
    out_ready = 1'b1;
    mask      = 8'h00;
    req_in    = 8'b0010_1000;
    tick();
    req_in = 8'h00;
    chk("lat_pending_c1", int'(pending), 8'h28);
    chk("lat_valid_c1", int'(out_valid), 0);
    tick();
    chk("lat_valid_c2", int'(out_valid), 1);
    chk("lat_pos_c2", int'(out_pos), 3);
    tick();
    chk("gap_valid_c3", int'(out_valid), 0);
    tick();
    chk("gap_valid_c4", int'(out_valid), 0);
    tick();
    chk("gap_valid_c5", int'(out_valid), 0);
    tick();
    chk("second_valid_c6", int'(out_valid), 1);
    chk("second_pos_c6", int'(out_pos), 5);
    tick();
    chk("after_pending", int'(pending), 0);

    // A grant on offer is not retracted when a lower index arrives
    do_reset();
    out_ready = 1'b0;
    req_in    = 8'h10;
    tick();
    req_in = 8'h00;
    tick();
    chk("hold4_pos", int'(out_pos), 4);
    req_in = 8'h01;
    tick();
    req_in = 8'h00;
    chk("hold4_valid_a", int'(out_valid), 1);
    chk("hold4_pos_a", int'(out_pos), 4);
    chk("hold4_pending", int'(pending), 8'h11);
    tick();
    chk("hold4_pos_b", int'(out_pos), 4);
    out_ready = 1'b1;
    tick();
    chk("hold4_released", int'(out_valid), 0);
    wait_valid(10, ok);
    chk("next0_seen", int'(ok), 1);
    chk("next0_pos", int'(out_pos), 0);
    tick();
    out_ready = 1'b0;

    // Collisions on a masked pending bit, then saturation, then unmask
    do_reset();
    mask   = 8'h04;
    req_in = 8'h04;
    tick();
    for (int k = 0; k < 3; k++) begin
      req_in = 8'h04;
      tick();
      req_in = 8'h00;
      tick();
    end
    chk("drop_three", int'(drop_count), 3);
    chk("masked_idle", int'(out_valid), 0);
    req_in = 8'h04;
    repeat (300) tick();
    req_in = 8'h00;
    chk("drop_sat", int'(drop_count), 255);
    mask      = 8'h00;
    out_ready = 1'b1;
    wait_valid(8, ok);
    chk("unmask_seen", int'(ok), 1);
    chk("unmask_pos", int'(out_pos), 2);
    tick();
    out_ready = 1'b0;

    // Re-request of the source being accepted in the same cycle
    do_reset();
    req_in = 8'h40;
    tick();
    req_in = 8'h00;
    tick();
    chk("same6_pos", int'(out_pos), 6);
    req_in    = 8'h40;
    out_ready = 1'b1;
    tick();
    req_in = 8'h00;
    chk("same6_valid", int'(out_valid), 0);
    chk("same6_pending", int'(pending), 8'h40);
    chk("same6_drop", int'(drop_count), 0);
    wait_valid(8, ok);
    chk("same6_regrant_seen", int'(ok), 1);
    chk("same6_regrant_pos", int'(out_pos), 6);
    tick();
    out_ready = 1'b0;

    // Masked low bit, then reset during an offer with requests present
    do_reset();
    mask   = 8'h01;
    req_in = 8'h81;
    tick();
    req_in = 8'h00;
    tick();
    chk("mask_valid", int'(out_valid), 1);
    chk("mask_pos", int'(out_pos), 7);
    reset     = 1'b1;
    req_in    = 8'hFF;
    out_ready = 1'b1;
    tick();
    reset  = 1'b0;
    req_in = 8'h00;
    mask   = 8'h00;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_pending", int'(pending), 0);
    chk("midrst_drop", int'(drop_count), 0);

    // Randomized traffic checked cycle by cycle against the model
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      req_in    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      if ((n % 16) == 0) mask = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    reset  = 1'b0;
    req_in = 8'h00;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pending_request_scheduler.md
PENDING_REQUEST_SCHEDULER -- requirements
Module: pending_request_scheduler

Interface
REQ-001 SHALL have parameter HOLDOFF, default 2, idle cycles inserted after each accepted grant (legal range 0..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_in  input  8  one-cycle request pulses; bit i requests service for source i.
REQ-005 SHALL have port mask  input  8  bit i = 1 makes pending source i ineligible for selection.
REQ-006 SHALL have port out_ready  input  1  consumer accepts the offered grant.
REQ-007 SHALL have port out_valid  output  1  a grant is being offered.
REQ-008 SHALL have port out_pos  output  3  index of the granted source; meaningful only while out_valid = 1.
REQ-009 SHALL have port pending  output  8  registered pending-request vector.
REQ-010 SHALL have port drop_count  output  8  saturating count of cycles in which a request collided with an already-pending bit.

Function
REQ-011 SHALL set pending[i] at the clock edge where req_in[i] = 1.
REQ-012 SHALL clear pending[out_pos] at the edge where out_valid && out_ready, unless req_in[out_pos] = 1 in that cycle, in which case pending[out_pos] stays 1 (new request retained, no drop counted).
REQ-013 SHALL increment drop_count by exactly 1 per cycle in which any bit has req_in[i] = 1 and pending[i] = 1 and i is not being cleared that cycle; saturate at 255, no wrap.
REQ-014 SHALL implement states IDLE, OFFER, HOLD; out_valid = 1 only in OFFER.
REQ-015 SHALL in IDLE compute eligible = pending & ~mask; if nonzero, latch out_pos = lowest set index of eligible and enter OFFER at the next edge; else remain IDLE.
REQ-016 SHALL hold out_pos and out_valid stable in OFFER until out_valid && out_ready, regardless of new requests, lower-index arrivals or mask changes (no retraction).
REQ-017 SHALL on handshake go to HOLD when HOLDOFF > 0, else directly to IDLE.
REQ-018 SHALL remain in HOLD for exactly HOLDOFF cycles (4-bit down-counter), then enter IDLE.
REQ-019 SHALL give latency: req_in pulse in cycle 0 with state IDLE and nothing pending -> pending visible in cycle 1 -> out_valid = 1 in cycle 2.
REQ-020 SHALL give spacing: handshake in cycle t -> HOLD in t+1..t+HOLDOFF, IDLE in t+HOLDOFF+1, next out_valid earliest t+HOLDOFF+2.
REQ-021 SHALL continue capturing requests and counting drops in every state.
REQ-022 SHALL treat out_ready as don't-care outside OFFER.
REQ-023 SHALL, with all pending bits masked, stay IDLE while pending keeps its value; unmasking makes the bit selectable at the next IDLE evaluation.

Reset
REQ-024 SHALL on reset = 1 at an edge force state IDLE, pending = 8'h00, out_valid = 0, out_pos = 3'd0, drop_count = 8'h00, HOLD counter = 0.
REQ-025 SHALL give reset priority over req_in, out_ready and any in-progress offer or holdoff; requests presented in a reset cycle are discarded.

Verification
REQ-026 SHALL cover: req_in = 8'b0010_1000 in cycle 0, mask = 0, out_ready = 1 -> out_valid in cycle 2 with out_pos = 3; HOLDOFF = 2 -> next out_valid in cycle 6 with out_pos = 5; pending = 0 afterwards.
REQ-027 SHALL cover: OFFER out_pos = 4 with out_ready = 0; pulse req_in[0] -> out_pos stays 4 until ready; after handshake the next grant is out_pos = 0.
REQ-028 SHALL cover: pending[2] = 1, pulse req_in[2] three times in separate cycles without service -> drop_count = 3; 300 such collision cycles -> drop_count = 255.
REQ-029 SHALL cover: handshake on out_pos = 6 with req_in[6] = 1 in the same cycle -> pending[6] remains 1, drop_count unchanged, source 6 granted again.
REQ-030 SHALL cover: pending = 8'h81, mask = 8'h01 -> out_pos = 7; reset asserted mid-OFFER -> next cycle out_valid = 0, pending = 0, drop_count = 0.
